// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR recovery controller.
// The harts are always a triple, so the package fixes the hart count.
package tmr_pkg;

    localparam int NHARTS_TMR = 3;
    localparam int HART_IDX_W = $clog2(NHARTS_TMR);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT      = 3'd1,
        ST_WAIT_HALT = 3'd2,
        ST_RESYNC    = 3'd3,
        ST_WAIT_RUN  = 3'd4,
        ST_FATAL     = 3'd5
    } tmr_rec_state_e;

    // Returns {valid, idx}; valid only when exactly one bit of vec is set.
    function automatic logic [HART_IDX_W:0] onehot_idx(input logic [NHARTS_TMR-1:0] vec);
        logic [HART_IDX_W:0] res;
        int                  ones;
        res  = '0;
        ones = 0;
        for (int i = 0; i < NHARTS_TMR; i++) begin
            if (vec[i]) begin
                ones++;
                res[HART_IDX_W-1:0] = HART_IDX_W'(i);
            end
        end
        res[HART_IDX_W] = (ones == 1);
        return res;
    endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Per-hart saturating fault counter; a clear in the same cycle as an
// increment wins.
module tmr_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr_i) begin
            cnt_next = '0;
        end else if (inc_i && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer for a TMR hart triple: halt all, resync the faulty hart,
// release all. The voter report is registered on entry, so error_i in cycle N
// raises halt_req_o in cycle N+2.
module tmr_recovery_ctrl
    import tmr_pkg::*;
#(
    parameter int NHARTS      = 3,
    parameter int CNT_W       = 4,
    parameter int MAX_FAULTS  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      error_i,
    input  logic [NHARTS-1:0]         error_id_i,
    input  logic [NHARTS-1:0]         halted_i,
    input  logic                      resync_done_i,
    input  logic                      clear_i,
    output logic [NHARTS-1:0]         halt_req_o,
    output logic                      resync_start_o,
    output logic [$clog2(NHARTS)-1:0] resync_id_o,
    output logic                      busy_o,
    output logic                      fatal_o,
    output logic                      overrun_o,
    output logic [NHARTS*CNT_W-1:0]   fault_cnt_o
);

    localparam int               IDX_W     = $clog2(NHARTS);
    localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FAULT_LIM = CNT_W'(MAX_FAULTS);

    tmr_rec_state_e    state_reg, state_next;
    logic              err_vld_reg;
    logic [NHARTS-1:0] err_id_reg;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [IDX_W-1:0]  id_reg, id_next;
    logic              start_reg, start_next;
    logic              ovr_reg, ovr_next;

    logic [IDX_W:0]    err_dec;
    logic [NHARTS-1:0] cnt_inc;
    logic [CNT_W-1:0]  cnt_arr [NHARTS];
    logic [CNT_W-1:0]  sel_cnt;
    logic [CNT_W-1:0]  sel_cnt_inc;
    logic              in_wait;
    logic              tmo_hit;
    logic              all_halted;
    logic              all_running;

    assign err_dec     = onehot_idx(err_id_reg);
    assign all_halted  = &halted_i;
    assign all_running = ~|halted_i;
    assign in_wait     = state_reg inside {ST_WAIT_HALT, ST_RESYNC, ST_WAIT_RUN};
    assign tmo_hit     = in_wait && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));
    assign sel_cnt     = cnt_arr[err_dec[IDX_W-1:0]];
    // Threshold decision uses the post-increment value, saturated like the counter.
    assign sel_cnt_inc = (sel_cnt == CNT_MAX) ? sel_cnt : sel_cnt + 1'b1;

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        start_next = 1'b0;
        cnt_inc    = '0;
        ovr_next   = ovr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (err_vld_reg) begin
                    if (err_dec[IDX_W]) begin
                        id_next                      = err_dec[IDX_W-1:0];
                        cnt_inc[err_dec[IDX_W-1:0]]  = 1'b1;
                        state_next = (sel_cnt_inc >= FAULT_LIM) ? ST_FATAL : ST_HALT;
                    end else begin
                        state_next = ST_FATAL;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_WAIT_HALT;
            end
            ST_WAIT_HALT: begin
                if (all_halted) begin
                    state_next = ST_RESYNC;
                    start_next = 1'b1;
                end else if (tmo_hit) begin
                    state_next = ST_FATAL;
                end
            end
            ST_RESYNC: begin
                if (resync_done_i) begin
                    state_next = ST_WAIT_RUN;
                end else if (tmo_hit) begin
                    state_next = ST_FATAL;
                end
            end
            ST_WAIT_RUN: begin
                if (all_running) begin
                    state_next = ST_IDLE;
                end else if (tmo_hit) begin
                    state_next = ST_FATAL;
                end
            end
            ST_FATAL: begin
                if (clear_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Reports arriving mid-recovery are dropped but flagged; FATAL ignores them.
        if (err_vld_reg && !(state_reg inside {ST_IDLE, ST_FATAL})) begin
            ovr_next = 1'b1;
        end
        if (clear_i) begin
            ovr_next = 1'b0;
        end

        tmo_next = (in_wait && (state_next == state_reg)) ? tmo_reg + 1'b1 : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            err_vld_reg <= 1'b0;
            err_id_reg  <= '0;
            tmo_reg     <= '0;
            id_reg      <= '0;
            start_reg   <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_vld_reg <= error_i;
            err_id_reg  <= error_id_i;
            tmo_reg     <= tmo_next;
            id_reg      <= id_next;
            start_reg   <= start_next;
            ovr_reg     <= ovr_next;
        end
    end

    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_cnt
        tmr_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (cnt_inc[gi]),
            .clr_i  (clear_i),
            .cnt_o  (cnt_arr[gi])
        );
        assign fault_cnt_o[gi*CNT_W +: CNT_W] = cnt_arr[gi];
    end

    assign halt_req_o     = {NHARTS{state_reg inside {ST_HALT, ST_WAIT_HALT, ST_RESYNC, ST_FATAL}}};
    assign resync_start_o = start_reg;
    assign resync_id_o    = id_reg;
    assign busy_o         = (state_reg != ST_IDLE);
    assign fatal_o        = (state_reg == ST_FATAL);
    assign overrun_o      = ovr_reg;

endmodule

// File: doc/tmr_recovery_ctrl.md
Name: tmr_recovery_ctrl

Overview:
Consumes the mismatch report produced by the triple-modular-redundancy bus voter and drives the recovery sequence for the faulty hart. The sequence halts all harts, has the resynchronisation unit copy the architectural state into the faulty hart, and then releases all harts. The block keeps saturating per-hart fault counters. It escalates to a sticky fatal state on multi-hart disagreement, on a fault-count threshold, or on a handshake timeout.

Parameters:
NHARTS, 3, number of redundant harts; must be 3.
CNT_W, 4, width of each per-hart fault counter.
MAX_FAULTS, 8, a hart whose counter reaches this value after an increment triggers FATAL instead of recovery; must be <= 2**CNT_W-1.
TIMEOUT_CYC, 1024, cycles allowed in WAIT_HALT, RESYNC or WAIT_RUN before FATAL.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
error_i  in  1  voter mismatch strobe, sampled each cycle.
error_id_i  in  NHARTS  voter one-hot faulty-hart indication, valid with error_i.
halted_i  in  NHARTS  per-hart halted/sleep status.
resync_done_i  in  1  single-cycle pulse from the resync unit when the state copy is complete.
clear_i  in  1  software clear: counters, sticky flags, exit from FATAL.
halt_req_o  out  NHARTS  halt request to every hart.
resync_start_o  out  1  single-cycle start pulse to the resync unit.
resync_id_o  out  $clog2(NHARTS)  index of the hart to be overwritten; stable while busy_o.
busy_o  out  1  high in any state other than IDLE.
fatal_o  out  1  sticky unrecoverable-fault flag.
overrun_o  out  1  sticky flag: error_i seen while not in IDLE.
fault_cnt_o  out  NHARTS*CNT_W  per-hart saturating counters; hart i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs 0, all counters 0, timeout counter 0.
- States: IDLE, HALT, WAIT_HALT, RESYNC, WAIT_RUN, FATAL. State is registered; outputs decode from state and registers only, with no combinational path from inputs to outputs.
- IDLE, error_i=1 with exactly one bit of error_id_i set:
  - latch the index into resync_id_o;
  - increment that hart's counter, saturating at 2**CNT_W-1;
  - if the new count >= MAX_FAULTS, go to FATAL; otherwise go to HALT.
- IDLE, error_i=1 with zero bits or more than one bit of error_id_i set: go to FATAL; counters unchanged.
- HALT: halt_req_o is all ones from this state until WAIT_RUN is entered. Go to WAIT_HALT on the next cycle; the timeout counter clears here.
- WAIT_HALT: wait for halted_i all ones, then go to RESYNC, asserting resync_start_o for exactly one cycle on entry.
- RESYNC: wait for resync_done_i. A resync_done_i pulse that coincides with the resync_start_o cycle is accepted. Then go to WAIT_RUN with halt_req_o = 0.
- WAIT_RUN: wait for halted_i all zeros, then go to IDLE.
- Timeout: the timeout counter increments every cycle in WAIT_HALT, RESYNC and WAIT_RUN, and clears on every state change. Reaching TIMEOUT_CYC goes to FATAL.
- FATAL:
  - fatal_o=1 and halt_req_o all ones;
  - resync_start_o is never asserted;
  - only clear_i leaves this state (to IDLE, with halt_req_o released on the next cycle).
- clear_i in any state: zero counters, overrun_o and fatal_o. Outside FATAL the state is unaffected, and an in-flight recovery completes normally.
- clear_i and an increment in the same cycle: clear wins; the counter reads 0.
- error_i in any state other than IDLE: not processed, not counted; overrun_o is set. Exception: in FATAL it is silently ignored.
- Reset asserted mid-recovery: immediate return to the reset values. The resync unit and the harts must tolerate the abrupt halt_req_o deassertion.
- Latency: error_i in cycle N gives halt_req_o high in cycle N+2 (registered IDLE->HALT).

Decomposition:
- Package tmr_pkg holds:
  - the state enum tmr_rec_state_e;
  - NHARTS_TMR=3;
  - function onehot_idx(), returning {valid, idx} for exactly one bit set.
- One sub-module, tmr_sat_counter (CNT_W, inc_i, clr_i, cnt_o, saturating), is instantiated NHARTS times.

Test Plan:
1. Single fault on hart 1: error_i=1 with error_id_i=3'b010. Then halted_i=3'b111 after 5 cycles, resync_done_i 10 cycles after start, and halted_i=0. Expect:
   - halt_req_o=3'b111 at N+2;
   - one resync_start_o pulse with resync_id_o=1;
   - fault_cnt_o hart1=1;
   - return to IDLE with busy_o=0.
2. Multi-hart disagreement: error_id_i=3'b011 -> FATAL next cycle, fatal_o=1, halt_req_o=3'b111, counters unchanged. Then clear_i=1 -> IDLE, fatal_o=0, halt_req_o=0.
3. Threshold: eight recoveries of hart 2 (MAX_FAULTS=8). Recoveries 1-7 complete normally; the 8th goes straight to FATAL with no resync_start_o, and fault_cnt_o hart2=8.
4. Timeout: hold halted_i=3'b101 after an error on hart 0 -> FATAL exactly TIMEOUT_CYC cycles after WAIT_HALT entry.
5. Overrun: error_i pulsed during RESYNC -> overrun_o=1, counters unchanged, recovery completes. Also assert clear_i together with an increment -> counter reads 0.
6. Asynchronous reset asserted during WAIT_HALT -> all outputs 0 immediately without a clock edge, and the FSM is in IDLE after release.
